// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU datapath width and result/flag bus type
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] sum;
    logic                 cout;
    logic                 overflow;
    logic                 zero;
  } alu_result_t;

endpackage

// File: rtl/full_adder_1bit.sv
// rtl/full_adder_1bit.sv - single-bit full adder cell of the ripple chain
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_4bit_reg.sv
// rtl/adder_4bit_reg.sv - registered ripple-carry adder with carry, overflow and zero flags
module adder_4bit_reg
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] core_sum;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_1bit u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry[i]),
      .s    (core_sum[i]),
      .cout (carry[i+1])
    );
  end

  // Result registers only load on in_valid, so X operands on idle cycles never reach them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      Overflow  <= 1'b0;
      Zero      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum      <= core_sum;
        Cout     <= carry[WIDTH];
        Overflow <= carry[WIDTH] ^ carry[WIDTH-1];
        Zero     <= (core_sum == '0);
      end
    end
  end

endmodule

// File: tb/tb_adder_4bit_reg.sv
// tb/tb_adder_4bit_reg.sv - self-checking bench for adder_4bit_reg against an arithmetic model
module tb_adder_4bit_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic       out_valid;
  logic [3:0] Sum;
  logic       Cout;
  logic       Overflow;
  logic       Zero;

  int checks = 0;
  int errors = 0;

  int e_valid, e_sum, e_cout, e_ovf, e_zero;

  always #5 clk = ~clk;

  adder_4bit_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .Sum       (Sum),
    .Cout      (Cout),
    .Overflow  (Overflow),
    .Zero      (Zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
    chk({tag, ".sum"},       32'(Sum),       32'(e_sum));
    chk({tag, ".cout"},      32'(Cout),      32'(e_cout));
    chk({tag, ".overflow"},  32'(Overflow),  32'(e_ovf));
    chk({tag, ".zero"},      32'(Zero),      32'(e_zero));
  endtask

  task automatic model_clear();
    e_valid = 0; e_sum = 0; e_cout = 0; e_ovf = 0; e_zero = 0;
  endtask

  // Reference: plain integer and signed arithmetic on the operand values.
  task automatic model_load(input int a, input int b, input int c);
    int total, sa, sb, ssum;
    total  = a + b + c;
    e_sum  = total % 16;
    e_cout = total / 16;
    e_zero = (e_sum == 0);
    sa     = (a >= 8) ? a - 16 : a;
    sb     = (b >= 8) ? b - 16 : b;
    ssum   = sa + sb + c;
    e_ovf  = (ssum > 7 || ssum < -8);
  endtask

  task automatic apply(input int a, input int b, input int c, input bit v, input string tag);
    @(negedge clk);
    in_valid = v;
    if (v) begin
      A = 4'(a); B = 4'(b); Cin = c[0];
      model_load(a, b, c);
    end else begin
      A = 'x; B = 'x; Cin = 1'bx;
    end
    e_valid = v;
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; A = 4'h5; B = 4'h5; Cin = 1'b0;
    model_clear();
    #1;
    chk_all("reset_async");
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    apply(4'b0011, 4'b0001, 0, 1'b1, "basic");
    apply(4'b1111, 4'b0001, 1, 1'b1, "carry");
    apply(4'hF, 4'h1, 0, 1'b1, "zero_wrap");
    apply(4'h7, 4'h1, 0, 1'b1, "ovf_pos");
    apply(4'h8, 4'h8, 0, 1'b1, "ovf_neg");
    apply(4'hF, 4'hF, 1, 1'b1, "max");

    apply(3, 1, 0, 1'b1, "b2b_0");
    apply(15, 1, 1, 1'b1, "b2b_1");
    apply(0, 0, 0, 1'b0, "hold");
    chk("hold.sum_literal", 32'(Sum), 32'h1);
    apply(0, 0, 0, 1'b0, "hold2");

    // Asynchronous reset between clock edges.
    apply(9, 4, 1, 1'b1, "pre_reset");
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk_all("reset_mid");
    @(negedge clk);
    in_valid = 1'b1; A = 4'h5; B = 4'h6; Cin = 1'b1;
    @(posedge clk);
    #1;
    chk_all("reset_drop");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 512; i++) begin
      apply(i % 16, (i / 16) % 16, i / 256, 1'b1, "exhaustive");
    end

    for (int i = 0; i < 200; i++) begin
      apply(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)),
            1'($urandom_range(3) != 0), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
